// File: rtl/ascon_xor_end.sv
// ASCON-128 end-of-phase XOR stage: folds the key into S3/S4 and optionally
// flips the S4 LSB for domain separation, then registers the full state.
module ascon_xor_end (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic [127:0]      key_i,
    input  logic              en_xor_key_end_i,
    input  logic              en_xor_lsb_i,
    input  logic [4:0][63:0]  state_i,
    output logic [4:0][63:0]  state_o
);

    logic [63:0]       w_key_hi;
    logic [63:0]       w_key_lo;
    logic [63:0]       w_lsb;
    logic [4:0][63:0]  w_next;
    logic [4:0][63:0]  r_state;

    // Select the XOR masks from the enables; a disabled mask is all-zero
    always_comb begin
        w_key_hi = 64'h0;
        w_key_lo = 64'h0;
        w_lsb    = 64'h0;
        if (en_xor_key_end_i) begin
            w_key_hi = key_i[127:64];
            w_key_lo = key_i[63:0];
        end else begin
            w_key_hi = 64'h0;
            w_key_lo = 64'h0;
        end
        if (en_xor_lsb_i) begin
            w_lsb = 64'h1;
        end else begin
            w_lsb = 64'h0;
        end
    end

    // Both masks land on S4; XOR commutes, so their order does not matter
    assign w_next = {state_i[4] ^ w_key_lo ^ w_lsb,
                     state_i[3] ^ w_key_hi,
                     state_i[2],
                     state_i[1],
                     state_i[0]};

    // Output register, cleared asynchronously and reloaded every cycle
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= {5{64'h0}};
        end else begin
            r_state <= w_next;
        end
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_ascon_xor_end.sv
// Self-checking bench for ascon_xor_end: directed key/LSB vectors, random
// streaming through a scoreboard queue, and asynchronous reset checks.
module tb_ascon_xor_end;

    logic              clk;
    logic              resetb_i;
    logic [127:0]      key_i;
    logic              en_xor_key_end_i;
    logic              en_xor_lsb_i;
    logic [4:0][63:0]  state_i;
    logic [4:0][63:0]  state_o;

    logic [4:0][63:0]  exp_q [$];
    logic [4:0][63:0]  last_exp;
    int                n_checks;
    int                n_fail;

    ascon_xor_end dut (
        .clock_i          (clk),
        .resetb_i         (resetb_i),
        .key_i            (key_i),
        .en_xor_key_end_i (en_xor_key_end_i),
        .en_xor_lsb_i     (en_xor_lsb_i),
        .state_i          (state_i),
        .state_o          (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: independent mask built over the flattened state
    function automatic logic [4:0][63:0] model(input logic [4:0][63:0] s,
                                                input logic [127:0] k,
                                                input logic ek, input logic el);
        logic [319:0] mask;
        mask = 320'h0;
        if (ek) mask[255:192] = k[127:64];
        if (ek) mask[319:256] = k[63:0];
        mask[256] = mask[256] ^ el;
        return s ^ mask;
    endfunction

    task automatic check(input string tag, input logic [4:0][63:0] obs,
                         input logic [4:0][63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after a falling edge and queue the expected result
    task automatic drive(input logic [4:0][63:0] s, input logic [127:0] k,
                         input logic ek, input logic el,
                         input logic [4:0][63:0] exp);
        @(negedge clk);
        state_i          = s;
        key_i            = k;
        en_xor_key_end_i = ek;
        en_xor_lsb_i     = el;
        exp_q.push_back(exp);
    endtask

    task automatic sample(input string tag);
        logic [4:0][63:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, state_o, e);
            last_exp = e;
        end
    endtask

    logic [127:0]      k_vec;
    logic [4:0][63:0]  s_vec;
    logic [4:0][63:0]  e_key;
    logic [4:0][63:0]  e_lsb;
    logic [4:0][63:0]  e_both;
    logic [4:0][63:0]  rs;
    logic [127:0]      rk;
    logic              rek;
    logic              rel;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_exp = {5{64'h0}};
        k_vec  = 128'h000102030405060708090A0B0C0D0E0F;
        s_vec  = {64'hf44a7ed98e1d9c83, 64'hc0c4757ca2646459, 64'hd7e8abaf45f2885a,
                  64'h6f140401cfa0873c, 64'h1b1354db77e0dbb4};
        e_key  = {64'hfc4374d28210928c, 64'hc0c5777fa661625e, s_vec[2], s_vec[1], s_vec[0]};
        e_lsb  = {64'hf44a7ed98e1d9c82, s_vec[3], s_vec[2], s_vec[1], s_vec[0]};
        e_both = {64'hfc4374d28210928d, 64'hc0c5777fa661625e, s_vec[2], s_vec[1], s_vec[0]};

        resetb_i         = 1'b1;
        key_i            = k_vec;
        en_xor_key_end_i = 1'b1;
        en_xor_lsb_i     = 1'b1;
        state_i          = s_vec;

        // Load a non-zero value, then reset asynchronously between edges
        drive(s_vec, k_vec, 1'b1, 1'b1, e_both);
        sample("preload_both");
        @(negedge clk);
        #2 resetb_i = 1'b0;
        #1 check("reset_async", state_o, {5{64'h0}});
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 check("reset_held", state_o, {5{64'h0}});

        // Directed vectors
        @(negedge clk);
        resetb_i = 1'b1;
        drive(s_vec, k_vec, 1'b1, 1'b0, e_key);
        sample("key_xor");
        drive(s_vec, k_vec, 1'b0, 1'b1, e_lsb);
        sample("lsb_flip");
        drive(s_vec, k_vec, 1'b1, 1'b1, e_both);
        sample("both_en");
        drive(s_vec, k_vec, 1'b0, 1'b0, s_vec);
        sample("pass_plain");

        // Random streaming: pass-through, then toggling enables
        for (int i = 0; i < 24; i++) begin
            rs  = {$urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom};
            rk  = {$urandom, $urandom, $urandom, $urandom};
            rek = (i >= 12) ? i[0] : 1'b0;
            rel = (i >= 12) ? i[1] : 1'b0;
            drive(rs, rk, rek, rel, model(rs, rk, rek, rel));
            #1 check("latency_hold", state_o, last_exp);
            sample((i < 12) ? "stream_pass" : "stream_toggle");
        end

        // Reset in the middle of a stream, then first edge after release
        rs = {$urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom};
        drive(rs, k_vec, 1'b1, 1'b0, model(rs, k_vec, 1'b1, 1'b0));
        #2 resetb_i = 1'b0;
        #1 check("reset_mid", state_o, {5{64'h0}});
        exp_q.delete();
        @(posedge clk);
        #1 check("reset_mid_held", state_o, {5{64'h0}});
        @(negedge clk);
        resetb_i = 1'b1;
        exp_q.push_back(model(rs, k_vec, 1'b1, 1'b0));
        sample("post_reset_first");
        drive(s_vec, k_vec, 1'b0, 1'b1, e_lsb);
        sample("post_reset_lsb");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
